// File: rtl/msg_pkg.sv
// Shared types and sizing constants for the length-prefixed frame assembler.
// MSG_ASM_CHECKSUM_EN adds the CHECK state used for the trailing XOR checksum byte.
package msg_pkg;

  localparam int MAX_LEN_DEF        = 64;
  localparam int TIMEOUT_CYCLES_DEF = 100000;
  localparam int ADDR_W_DEF         = $clog2(MAX_LEN_DEF);
  localparam int LEN_W_DEF          = $clog2(MAX_LEN_DEF) + 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PAYLOAD = 3'd1,
`ifdef MSG_ASM_CHECKSUM_EN
    ST_CHECK   = 3'd2,
`endif
    ST_DONE    = 3'd3,
    ST_LOCKED  = 3'd4
  } state_t;

  function automatic int addr_w(input int max_len);
    return $clog2(max_len);
  endfunction

  function automatic int len_w(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

endpackage

// File: rtl/msg_assembler_if.sv
// Byte stream in, frame buffer read port and status out for msg_assembler.
// rx_valid is a one-cycle strobe with no backpressure: every strobed byte is consumed on that edge.
interface msg_assembler_if
  import msg_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF
);
  logic                       rx_valid;
  logic [7:0]                 rx_data;
  logic                       consumer_busy;
  logic                       finished_receiving;
  logic [$clog2(MAX_LEN):0]   msg_len;
  logic [$clog2(MAX_LEN)-1:0] rd_addr;
  logic [7:0]                 rd_data;
  logic                       frame_error;
  logic [7:0]                 overrun_count;

  modport slave (
    input  rx_valid, rx_data, consumer_busy, rd_addr,
    output finished_receiving, msg_len, rd_data, frame_error, overrun_count
  );

  modport master (
    output rx_valid, rx_data, consumer_busy, rd_addr,
    input  finished_receiving, msg_len, rd_data, frame_error, overrun_count
  );
endinterface

// File: rtl/msg_buffer.sv
// Payload storage: one write port, one registered read port (read-first on a same-address write).
module msg_buffer #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];

  // Storage itself is never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= 8'd0;
    else        rdata <= mem[raddr];
  end
endmodule

// File: rtl/msg_assembler.sv
// Collects a length byte plus N payload bytes into msg_buffer and hands the frame to a consumer.
// Define MSG_ASM_CHECKSUM_EN to require a trailing XOR checksum byte.
module msg_assembler
  import msg_pkg::*;
#(
  parameter int MAX_LEN        = MAX_LEN_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           rst_i,
  msg_assembler_if.slave bus,
  output state_t         state
);
  localparam int AW = addr_w(MAX_LEN);
  localparam int LW = len_w(MAX_LEN);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // Assert asynchronously, release on the second clock edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  state_t        state_nxt;
  logic [LW-1:0] len_q;
  logic [LW-1:0] ptr;
  logic [TW-1:0] timer;
  logic          busy_seen;
  logic [7:0]    ovr;
  logic          fr_q, fe_q;
  logic [7:0]    rd_data;
  logic          len_ok, last_byte, timeout;
  logic          wr_en, len_ld, drop, in_frame, fr_d, fe_d;

  assign len_ok    = (bus.rx_data != 8'd0) && (int'(bus.rx_data) <= MAX_LEN);
  assign last_byte = (ptr + LW'(1)) == len_q;
  assign timeout   = (timer == TW'(TIMEOUT_CYCLES - 1)) && !bus.rx_valid;

`ifdef MSG_ASM_CHECKSUM_EN
  logic [7:0] csum;
  logic       sum_ok;
  assign sum_ok = (bus.rx_data == csum);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (bus.rx_valid && len_ok) state_nxt = ST_PAYLOAD;
      ST_PAYLOAD: begin
        if (timeout) state_nxt = ST_IDLE;
`ifdef MSG_ASM_CHECKSUM_EN
        else if (bus.rx_valid && last_byte) state_nxt = ST_CHECK;
`else
        else if (bus.rx_valid && last_byte) state_nxt = ST_DONE;
`endif
      end
`ifdef MSG_ASM_CHECKSUM_EN
      ST_CHECK: begin
        if (timeout)           state_nxt = ST_IDLE;
        else if (bus.rx_valid) state_nxt = sum_ok ? ST_DONE : ST_IDLE;
      end
`endif
      ST_DONE:    state_nxt = ST_LOCKED;
      ST_LOCKED:  if (busy_seen && !bus.consumer_busy) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_en    = 1'b0;
    len_ld   = 1'b0;
    drop     = 1'b0;
    in_frame = 1'b0;
    fr_d     = 1'b0;
    fe_d     = 1'b0;
    case (state)
      ST_IDLE: begin
        len_ld = bus.rx_valid && len_ok;
        fe_d   = bus.rx_valid && !len_ok;
      end
      ST_PAYLOAD: begin
        in_frame = 1'b1;
        wr_en    = bus.rx_valid;
        fe_d     = timeout;
      end
`ifdef MSG_ASM_CHECKSUM_EN
      ST_CHECK: begin
        in_frame = 1'b1;
        fe_d     = timeout || (bus.rx_valid && !sum_ok);
      end
`endif
      ST_DONE: begin
        fr_d = 1'b1;
        drop = bus.rx_valid;
      end
      ST_LOCKED: drop = bus.rx_valid;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q     <= '0;
      ptr       <= '0;
      timer     <= '0;
      busy_seen <= 1'b0;
      ovr       <= 8'd0;
      fr_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      fr_q <= fr_d;
      fe_q <= fe_d;
      if (len_ld) len_q <= LW'(bus.rx_data);
      if (len_ld)     ptr <= '0;
      else if (wr_en) ptr <= ptr + LW'(1);
      if (in_frame && !bus.rx_valid) timer <= timer + TW'(1);
      else                           timer <= '0;
      // A busy high seen in LOCKED arms the release on its falling edge.
      busy_seen <= (state == ST_LOCKED) && (state_nxt == ST_LOCKED) &&
                   (busy_seen || bus.consumer_busy);
      if (drop && ovr != 8'hFF) ovr <= ovr + 8'd1;
    end
  end

`ifdef MSG_ASM_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      csum <= 8'd0;
    else if (len_ld) csum <= bus.rx_data;
    else if (wr_en)  csum <= csum ^ bus.rx_data;
  end
`endif

  msg_buffer #(.DEPTH(MAX_LEN), .AW(AW)) u_buffer (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en),
    .waddr (ptr[AW-1:0]),
    .wdata (bus.rx_data),
    .raddr (bus.rd_addr),
    .rdata (rd_data)
  );

  assign bus.finished_receiving = fr_q;
  assign bus.frame_error        = fe_q;
  assign bus.msg_len            = len_q;
  assign bus.overrun_count      = ovr;
  assign bus.rd_data            = rd_data;
endmodule
